// File: rtl/ins_prefetch_pkg.sv
// Shared types and constants for the instruction prefetcher.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package ins_prefetch_pkg;

    // IDLE: no request outstanding. WAIT: request outstanding, data wanted.
    // DROP: request outstanding, but its data is stale after a redirect.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam int          DEF_DEPTH    = 4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0000_0000;

    // One queue entry: the fetch address and the word fetched from it.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } fetch_entry_t;

    // Redirect targets may carry junk in the byte-offset bits.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ins_prefetch_if.sv
// Bundle of the prefetcher's memory-side, core-side and redirect signals.
// Latency: n/a (wiring only).
// Backpressure: ins_ready from the core; imem_ack paces the memory side.
// Ports: imem_req/imem_addr/imem_ack/imem_rdata (memory), ins_valid/ins_ready/
//        ins_out/ins_pc (core), redirect/redirect_pc (branch unit).
//        master = prefetcher, slave = memory + core + branch unit.
interface ins_prefetch_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_out;
    logic [31:0] ins_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    modport master (
        output imem_req, imem_addr, ins_valid, ins_out, ins_pc,
        input  imem_ack, imem_rdata, ins_ready, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, ins_valid, ins_out, ins_pc,
        output imem_ack, imem_rdata, ins_ready, redirect, redirect_pc
    );

endinterface

// File: rtl/ins_fifo.sv
// Synchronous FIFO of {pc, ins} entries with flush; head is a plain register read.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must not push when full.
// Ports: clk, rst (sync active-low), push/push_dat, pop, flush,
//        count, head_vld, head_dat (zero when empty).
module ins_fifo
    import ins_prefetch_pkg::*;
#(
    parameter int  DEPTH = DEF_DEPTH,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  fetch_entry_t push_dat,
    input  logic         pop,
    input  logic         flush,
    output logic [CW-1:0] count,
    output logic         head_vld,
    output fetch_entry_t head_dat
);

    fetch_entry_t  mem [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic          do_push;
    logic          do_pop;

    assign head_vld = (count != '0);
    assign do_push  = push && (count != CW'(DEPTH));
    assign do_pop   = pop && head_vld;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) tail <= tail + 1'b1;
            if (do_pop)  head <= head + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: nothing reads it while count is zero.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[tail] <= push_dat;
    end

    assign head_dat = head_vld ? mem[head] : '0;

endmodule

// File: rtl/ins_prefetch.sv
// Instruction prefetcher: fetches sequential words ahead of the core into a small queue.
// Latency: request registered one cycle after space is seen; data at head the cycle after ack.
// Backpressure: stops requesting while the queue is full; ins_ready pops the head.
// Ports: clk, rst (sync active-low), bus (ins_prefetch_if.master).
module ins_prefetch
    import ins_prefetch_pkg::*;
#(
    parameter int          DEPTH    = DEF_DEPTH,
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic           clk,
    input  logic           rst,
    ins_prefetch_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_t        state;
    state_t        state_nxt;
    logic [31:0]   fetch_pc;
    logic [31:0]   fetch_pc_nxt;
    logic          req_nxt;
    logic [31:0]   addr_nxt;
    logic          push;
    logic          pop;
    fetch_entry_t  push_dat;
    logic [CW-1:0] count;
    logic          head_vld;
    fetch_entry_t  head_dat;
    logic          has_room;

    assign has_room = (count < CW'(DEPTH));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= IDLE;
            fetch_pc      <= RESET_PC;
            bus.imem_req  <= 1'b0;
            bus.imem_addr <= RESET_PC;
        end else begin
            state         <= state_nxt;
            fetch_pc      <= fetch_pc_nxt;
            bus.imem_req  <= req_nxt;
            bus.imem_addr <= addr_nxt;
        end
    end

    // imem_req/imem_addr hold by default so they stay stable until the ack.
    always_comb begin
        state_nxt    = state;
        fetch_pc_nxt = fetch_pc;
        req_nxt      = bus.imem_req;
        addr_nxt     = bus.imem_addr;
        push         = 1'b0;
        case (state)
            IDLE: begin
                // A redirect in IDLE only retargets; the request goes out next cycle.
                // Stray acks here are ignored.
                if (bus.redirect) begin
                    fetch_pc_nxt = word_align(bus.redirect_pc);
                end else if (has_room) begin
                    state_nxt = WAIT;
                    req_nxt   = 1'b1;
                    addr_nxt  = fetch_pc;
                end
            end
            WAIT: begin
                if (bus.redirect) begin
                    fetch_pc_nxt = word_align(bus.redirect_pc);
                    if (bus.imem_ack) begin
                        state_nxt = IDLE;
                        req_nxt   = 1'b0;
                    end else begin
                        state_nxt = DROP;
                    end
                end else if (bus.imem_ack) begin
                    push         = 1'b1;
                    fetch_pc_nxt = fetch_pc + PC_STEP;
                    state_nxt    = IDLE;
                    req_nxt      = 1'b0;
                end
            end
            DROP: begin
                // Keep the newest target; the in-flight word is discarded on its ack.
                if (bus.redirect) fetch_pc_nxt = word_align(bus.redirect_pc);
                if (bus.imem_ack) begin
                    state_nxt = IDLE;
                    req_nxt   = 1'b0;
                end
            end
            default: begin
                state_nxt = IDLE;
                req_nxt   = 1'b0;
            end
        endcase
    end

    assign push_dat = '{pc: fetch_pc, ins: bus.imem_rdata};
    // A redirect flushes the queue, so a same-cycle pop is meaningless.
    assign pop      = head_vld && bus.ins_ready && !bus.redirect;

    ins_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (bus.redirect),
        .count    (count),
        .head_vld (head_vld),
        .head_dat (head_dat)
    );

    assign bus.ins_valid = head_vld;
    assign bus.ins_out   = head_dat.ins;
    assign bus.ins_pc    = head_dat.pc;

endmodule

// File: tb/tb_ins_prefetch.sv
// Scoreboard bench for ins_prefetch: a memory/branch driver pushes expected
// queue entries as acks are accepted, and a core-side monitor pops and
// compares them whenever the core consumes the head.
module tb_ins_prefetch;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    ins_prefetch_if bus ();

    ins_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int n_req    = 0;
    int n_pops   = 0;

    // Reference model: expected queue contents and next fetch address.
    logic [63:0] exp_q [$];
    logic [31:0] exp_fetch;
    logic        outstanding;
    logic        dropped;
    logic        expect_req_low;
    logic [31:0] req_addr;
    int          ack_wait;

    // Stimulus knobs.
    int          ready_pct, redir_pct, stray_pct, dmin, dmax;
    int          trig_mode;          // 0 none, 1 redirect on issue, 2 redirect with ack
    logic [31:0] trig_addr, trig_pc;
    logic        force_vld;
    logic [31:0] force_pc;
    logic        rec_pops;
    int          pop_cyc [$];
    logic        saw_wrap;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name, input string why);
        n_checks++;
        n_fail++;
        $display("FAIL %s: %s (cycle %0d)", name, why, cyc);
    endtask

    always @(posedge clk) cyc++;

    // Core-side monitor.
    always @(negedge clk) begin
        logic [63:0] e;
        if (rst && bus.ins_valid && bus.ins_ready && !bus.redirect) begin
            if (exp_q.size() == 0) begin
                fail_now("pop_unexpected", "ins_valid high with nothing expected");
            end else begin
                e = exp_q.pop_front();
                check("pop_pc", {32'd0, bus.ins_pc}, {32'd0, e[63:32]});
                check("pop_ins", {32'd0, bus.ins_out}, {32'd0, e[31:0]});
                n_pops++;
                if (rec_pops) pop_cyc.push_back(cyc);
                if (bus.ins_pc == 32'hFFFF_FFFC) saw_wrap = 1'b1;
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        exp_fetch      = RESET_PC;
        outstanding    = 1'b0;
        dropped        = 1'b0;
        expect_req_low = 1'b0;
        n_req          = 0;
        trig_mode      = 0;
        force_vld      = 1'b0;
    endtask

    // Hold reset for one edge, check reset outputs, release with a stray ack.
    task automatic apply_reset();
        bus.imem_ack  = 1'b0;
        bus.redirect  = 1'b0;
        bus.ins_ready = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        check("rst_ins_valid", bus.ins_valid, 1'b0);
        check("rst_imem_req", bus.imem_req, 1'b0);
        check("rst_imem_addr", bus.imem_addr, RESET_PC);
        check("rst_ins_out", bus.ins_out, 32'd0);
        check("rst_ins_pc", bus.ins_pc, 32'd0);
        model_reset();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = $urandom();
        rst = 1'b1;
    endtask

    task automatic step();
        logic        do_ack, do_redir, stray, ready, new_req;
        logic [31:0] rpc;
        @(posedge clk); #1;
        check("valid_vs_model", bus.ins_valid, exp_q.size() != 0);
        if (!bus.ins_valid) check("empty_outputs_zero", {bus.ins_pc, bus.ins_out}, 64'd0);
        new_req = 1'b0;
        if (expect_req_low) begin
            check("req_low_after_ack", bus.imem_req, 1'b0);
            expect_req_low = 1'b0;
        end else if (outstanding) begin
            check("req_held", bus.imem_req, 1'b1);
            check("addr_held", bus.imem_addr, req_addr);
        end else if (bus.imem_req) begin
            check("fetch_addr", bus.imem_addr, exp_fetch);
            outstanding = 1'b1;
            dropped     = 1'b0;
            req_addr    = bus.imem_addr;
            ack_wait    = $urandom_range(dmax, dmin);
            n_req++;
            new_req     = 1'b1;
        end

        do_redir = ($urandom_range(99) < redir_pct);
        rpc      = $urandom();
        if ($urandom_range(3) == 0) rpc = 32'hFFFF_FFF0 | {28'd0, rpc[3:0]};
        ready    = ($urandom_range(99) < ready_pct);
        if (new_req && trig_mode == 1 && req_addr == trig_addr) begin
            do_redir  = 1'b1;
            rpc       = trig_pc;
            ack_wait  = 2;
            trig_mode = 0;
        end
        do_ack = 1'b0;
        if (outstanding) begin
            if (ack_wait == 0) do_ack = 1'b1;
            else ack_wait--;
        end
        if (do_ack && trig_mode == 2 && req_addr == trig_addr) begin
            do_redir  = 1'b1;
            rpc       = trig_pc;
            ready     = 1'b1;
            trig_mode = 0;
        end
        if (force_vld) begin
            do_redir  = 1'b1;
            rpc       = force_pc;
            force_vld = 1'b0;
        end
        stray = !outstanding && ($urandom_range(99) < stray_pct);

        bus.imem_ack    = do_ack | stray;
        bus.imem_rdata  = do_ack ? rom(req_addr) : $urandom();
        bus.redirect    = do_redir;
        bus.redirect_pc = rpc;
        bus.ins_ready   = ready;

        if (do_redir) begin
            exp_q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
            if (outstanding && !do_ack) dropped = 1'b1;
        end
        if (do_ack) begin
            if (!do_redir && !dropped) begin
                check("no_push_when_full", exp_q.size() < DEPTH, 1'b1);
                exp_q.push_back({req_addr, rom(req_addr)});
                exp_fetch = req_addr + 32'd4;
            end
            outstanding    = 1'b0;
            dropped        = 1'b0;
            expect_req_low = 1'b1;
        end
    endtask

    task automatic knobs(input int rdy, input int rdr, input int st, input int lo, input int hi);
        ready_pct = rdy; redir_pct = rdr; stray_pct = st; dmin = lo; dmax = hi;
    endtask

    initial begin
        int k;
        bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.ins_ready = 1'b0;
        bus.redirect = 1'b0; bus.redirect_pc = '0;
        rec_pops = 1'b0; saw_wrap = 1'b0;
        model_reset();
        knobs(100, 0, 0, 0, 0);

        // Streaming at the maximum rate: a word every other cycle.
        apply_reset();
        rec_pops = 1'b1;
        repeat (12) step();
        rec_pops = 1'b0;
        if (pop_cyc.size() < 4) fail_now("stream_pops", "fewer than 4 words reached the core");
        else for (int i = 0; i < 3; i++) check("stream_spacing", pop_cyc[i+1] - pop_cyc[i], 2);

        // Core stalled: exactly DEPTH fetches, then one pop frees room for 0x10.
        apply_reset();
        knobs(0, 0, 0, 0, 0);
        repeat (16) step();
        check("full_req_count", n_req, DEPTH);
        check("full_req_low", bus.imem_req, 1'b0);
        ready_pct = 100; step(); ready_pct = 0;
        repeat (3) step();
        check("refill_req_count", n_req, DEPTH + 1);

        // Redirect while fetching 0x8; its late ack must be dropped.
        apply_reset();
        knobs(100, 0, 0, 0, 0);
        trig_mode = 1; trig_addr = 32'h8; trig_pc = 32'h100;
        k = 0;
        while (trig_mode != 0 && k < 40) begin step(); k++; end
        if (trig_mode != 0) fail_now("drop_trigger", "no request for 0x8 seen");
        repeat (12) step();

        // Redirect to unaligned 0x203 on the ack cycle with ins_ready high.
        apply_reset();
        knobs(0, 0, 0, 0, 0);
        trig_mode = 2; trig_addr = 32'h8; trig_pc = 32'h203;
        k = 0;
        while (trig_mode != 0 && k < 40) begin step(); k++; end
        if (trig_mode != 0) fail_now("ack_redirect_trigger", "no ack for 0x8 issued");
        step();
        check("flush_on_redirect", bus.ins_valid, 1'b0);
        repeat (6) step();

        // Address wrap at the top of memory.
        apply_reset();
        knobs(100, 0, 0, 1, 1);
        force_vld = 1'b1; force_pc = 32'hFFFF_FFFC;
        repeat (14) step();
        check("wrap_entry_seen", saw_wrap, 1'b1);

        // Reset with a request in flight and two words queued.
        apply_reset();
        knobs(0, 0, 0, 1, 1);
        k = 0;
        while (!(exp_q.size() == 2 && outstanding) && k < 40) begin step(); k++; end
        if (!(exp_q.size() == 2 && outstanding)) fail_now("midreset_setup", "queue never held 2 with a fetch pending");
        apply_reset();
        step();
        check("first_req_after_reset", bus.imem_req, 1'b1);
        check("first_addr_after_reset", bus.imem_addr, RESET_PC);

        // Random traffic.
        knobs(60, 5, 5, 0, 3);
        repeat (3000) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        fail_now("watchdog", "simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
